gelato_idecode: RTL and testbench
=================================

Name: gelato_idecode

Overview:
- Consumer (I-Decode) end of the I-Fetch -> I-Decode link.
- Accepts one fetched instruction per cycle and consumes it by pulsing a clear back to I-Fetch.
- Decodes RV32 fields and the sign-extended immediate at accept time, then buffers decoded entries in a small FIFO.
- Presents the FIFO head to the issue stage with a valid/ready handshake; supports a global flush on pipeline redirect.

Parameters:
- ADDR_WIDTH, 32, width of pc.
- DATA_WIDTH, 32, width of instruction and immediate.
- WARP_NUM_WIDTH, 5, width of warp number.
- SPLIT_NUM_WIDTH, 3, width of split-table number.
- DEPTH, 2, decoded-entry FIFO depth (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ifetch_valid  in  1  I-Fetch has an instruction pending.
- ifetch_pc  in  ADDR_WIDTH  pc of the instruction.
- ifetch_warp_num  in  WARP_NUM_WIDTH  owning warp.
- ifetch_split_table_num  in  SPLIT_NUM_WIDTH  split-table entry.
- ifetch_inst  in  DATA_WIDTH  raw instruction word.
- ifetch_consume  out  1  pulse: instruction taken; I-Fetch clears valid at this edge.
- flush  in  1  drop all buffered entries.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  issue accepts head.
- dec_pc  out  ADDR_WIDTH  head pc.
- dec_warp_num  out  WARP_NUM_WIDTH  head warp.
- dec_split_table_num  out  SPLIT_NUM_WIDTH  head split entry.
- dec_opcode  out  7  inst[6:0].
- dec_rd  out  5  inst[11:7].
- dec_funct3  out  3  inst[14:12].
- dec_rs1  out  5  inst[19:15].
- dec_rs2  out  5  inst[24:20].
- dec_funct7  out  7  inst[31:25].
- dec_fmt  out  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- dec_imm  out  DATA_WIDTH  sign-extended immediate.
- dec_illegal  out  1  unrecognised opcode.

Behaviour:
- One clock domain, clk.
- rst is asynchronous and active-high.
- Reset state:
  - count=0, read/write pointers=0.
  - dec_valid=0, ifetch_consume=0.
  - Head data outputs read storage and are don't-care while dec_valid=0.
- Accept:
  - ifetch_consume = ifetch_valid & (count<DEPTH) & ~flush. It is combinational.
  - On the accepting edge the decoded entry is written at wptr.
  - There is no accept when full, even if a dequeue occurs in the same cycle.
  - I-Fetch drops or replaces valid at that edge, so there is no double accept.
- Latency: accept in cycle t -> entry visible on dec_* in cycle t+1 if the FIFO was empty.
- Dequeue: on dec_valid & dec_ready & ~flush, rptr advances.
- Outputs: dec_valid = (count!=0). The dec_* outputs are driven from the entry at rptr.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- Flush:
  - Next cycle: count=0 and pointers=0.
  - Overrides accept and dequeue in the same cycle.
  - An in-flight ifetch_valid is not consumed.
- Decode (combinational, stored per entry). Format by opcode:
  - 0110011 -> R, imm=0.
  - 0010011, 0000011, 1100111, 1110011 -> I, imm=sext(inst[31:20]).
  - 0100011 -> S, imm=sext({inst[31:25],inst[11:7]}).
  - 1100011 -> B, imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111 -> U, imm={inst[31:12],12'b0}.
  - 1101111 -> J, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Any other opcode -> fmt=7, dec_illegal=1, imm=0.
- Register fields are extracted unconditionally for every format.
- Reset mid-operation: all entries are discarded immediately. ifetch_consume is held 0 while rst is high.

Test Plan:
- Reset: assert rst with ifetch_valid=1 -> ifetch_consume=0 and dec_valid=0 throughout. After release, the first accept occurs in the first cycle.
- ADDI: inst=0x00500093, pc=0x80000000, warp=3, dec_ready=1 -> consume=1 in cycle t. In cycle t+1: dec_valid=1, rd=1, rs1=0, fmt=1, imm=0x00000005, pc=0x80000000, warp=3.
- Backpressure: dec_ready=0, offer 3 back-to-back instructions (pcs 0x0, 0x4, 0x8):
  - Two are accepted; the third sees consume=0 while count=2.
  - Raise dec_ready -> heads appear in order 0x0, 0x4, 0x8, and the third is accepted the cycle after the first dequeue.
- BEQ x1,x2,-4: inst=0xFE208EE3 -> fmt=3, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC. JAL inst=0x0080006F -> fmt=5, rd=0, imm=0x00000008.
- Illegal: inst=0x00000000 -> fmt=7, dec_illegal=1, imm=0. The entry is still buffered and dequeued normally.
- Flush: FIFO full, ifetch_valid=1 and dec_ready=1 with flush=1 in the same cycle:
  - ifetch_consume=0 that cycle.
  - Next cycle dec_valid=0.
  - A new instruction is then accepted and appears 1 cycle later.

Source files
------------

// File: rtl/gelato_idecode.sv
// gelato_idecode
//   Consumer end of the I-Fetch -> I-Decode link. Takes one fetched
//   instruction per cycle, decodes RV32 fields, format and sign-extended
//   immediate at accept time, and buffers the decoded entries in a small
//   FIFO. The FIFO head is presented to the issue stage with valid/ready.
//   flush drops every buffered entry and blocks the in-flight accept.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ifetch_valid/pc/warp_num/
//   ifetch_split_table_num/inst   instruction offered by I-Fetch
//   ifetch_consume                combinational pulse: instruction taken
//   flush                         drop all buffered entries
//   dec_valid / dec_ready         head handshake toward issue
//   dec_pc/warp_num/split_table_num, dec_opcode/rd/funct3/rs1/rs2/funct7,
//   dec_fmt/imm/illegal           decoded head entry
module gelato_idecode #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int WARP_NUM_WIDTH  = 5,
   parameter int SPLIT_NUM_WIDTH = 3,
   parameter int DEPTH           = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ifetch_valid,
   input  logic [ADDR_WIDTH-1:0]      ifetch_pc,
   input  logic [WARP_NUM_WIDTH-1:0]  ifetch_warp_num,
   input  logic [SPLIT_NUM_WIDTH-1:0] ifetch_split_table_num,
   input  logic [DATA_WIDTH-1:0]      ifetch_inst,
   output logic                       ifetch_consume,
   input  logic                       flush,
   output logic                       dec_valid,
   input  logic                       dec_ready,
   output logic [ADDR_WIDTH-1:0]      dec_pc,
   output logic [WARP_NUM_WIDTH-1:0]  dec_warp_num,
   output logic [SPLIT_NUM_WIDTH-1:0] dec_split_table_num,
   output logic [6:0]                 dec_opcode,
   output logic [4:0]                 dec_rd,
   output logic [2:0]                 dec_funct3,
   output logic [4:0]                 dec_rs1,
   output logic [4:0]                 dec_rs2,
   output logic [6:0]                 dec_funct7,
   output logic [2:0]                 dec_fmt,
   output logic [DATA_WIDTH-1:0]      dec_imm,
   output logic                       dec_illegal
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] count;
   logic             full, enq, deq;

   logic [2:0]            fmt_new;
   logic [31:0]           imm32_new;
   logic [DATA_WIDTH-1:0] imm_new;
   logic                  ill_new;

   logic [ADDR_WIDTH-1:0]      mem_pc    [DEPTH];
   logic [WARP_NUM_WIDTH-1:0]  mem_warp  [DEPTH];
   logic [SPLIT_NUM_WIDTH-1:0] mem_split [DEPTH];
   logic [31:0]                mem_inst  [DEPTH];
   logic [2:0]                 mem_fmt   [DEPTH];
   logic [DATA_WIDTH-1:0]      mem_imm   [DEPTH];
   logic                       mem_ill   [DEPTH];

   logic [31:0] head_inst;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign full      = (count == CNT_W'(DEPTH));
   assign dec_valid = (count != '0);

   // rst gates consume so I-Fetch never sees a take while reset is held.
   assign ifetch_consume = ifetch_valid & ~full & ~flush & ~rst;
   assign enq            = ifetch_consume;
   assign deq            = dec_valid & dec_ready & ~flush;

   always_comb begin
      fmt_new   = FMT_ILL;
      imm32_new = '0;
      ill_new   = 1'b1;
      case (ifetch_inst[6:0])
         7'b0110011: begin
            fmt_new = FMT_R;
            ill_new = 1'b0;
         end
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
            fmt_new   = FMT_I;
            ill_new   = 1'b0;
            imm32_new = {{20{ifetch_inst[31]}}, ifetch_inst[31:20]};
         end
         7'b0100011: begin
            fmt_new   = FMT_S;
            ill_new   = 1'b0;
            imm32_new = {{20{ifetch_inst[31]}}, ifetch_inst[31:25], ifetch_inst[11:7]};
         end
         7'b1100011: begin
            fmt_new   = FMT_B;
            ill_new   = 1'b0;
            imm32_new = {{19{ifetch_inst[31]}}, ifetch_inst[31], ifetch_inst[7],
                         ifetch_inst[30:25], ifetch_inst[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            fmt_new   = FMT_U;
            ill_new   = 1'b0;
            imm32_new = {ifetch_inst[31:12], 12'b0};
         end
         7'b1101111: begin
            fmt_new   = FMT_J;
            ill_new   = 1'b0;
            imm32_new = {{11{ifetch_inst[31]}}, ifetch_inst[31], ifetch_inst[19:12],
                         ifetch_inst[20], ifetch_inst[30:21], 1'b0};
         end
         default: begin
            fmt_new   = FMT_ILL;
            ill_new   = 1'b1;
            imm32_new = '0;
         end
      endcase
      imm_new = DATA_WIDTH'($signed(imm32_new));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (enq) wptr <= ptr_inc(wptr);
         if (deq) rptr <= ptr_inc(rptr);
         if (enq && !deq)      count <= count + CNT_W'(1);
         else if (!enq && deq) count <= count - CNT_W'(1);
      end
   end

   // Entry storage carries no reset: contents are only observed while valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_pc[wptr]    <= ifetch_pc;
         mem_warp[wptr]  <= ifetch_warp_num;
         mem_split[wptr] <= ifetch_split_table_num;
         mem_inst[wptr]  <= ifetch_inst[31:0];
         mem_fmt[wptr]   <= fmt_new;
         mem_imm[wptr]   <= imm_new;
         mem_ill[wptr]   <= ill_new;
      end
   end

   assign head_inst           = mem_inst[rptr];
   assign dec_pc              = mem_pc[rptr];
   assign dec_warp_num        = mem_warp[rptr];
   assign dec_split_table_num = mem_split[rptr];
   assign dec_fmt             = mem_fmt[rptr];
   assign dec_imm             = mem_imm[rptr];
   assign dec_illegal         = mem_ill[rptr];
   assign dec_opcode          = head_inst[6:0];
   assign dec_rd              = head_inst[11:7];
   assign dec_funct3          = head_inst[14:12];
   assign dec_rs1             = head_inst[19:15];
   assign dec_rs2             = head_inst[24:20];
   assign dec_funct7          = head_inst[31:25];

endmodule

// File: tb/tb_gelato_idecode.sv
// tb_gelato_idecode
//   Directed-vector bench for gelato_idecode with hand-computed expectations.
//   Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_gelato_idecode;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifetch_valid;
   logic [31:0] ifetch_pc;
   logic [4:0]  ifetch_warp_num;
   logic [2:0]  ifetch_split_table_num;
   logic [31:0] ifetch_inst;
   logic        ifetch_consume;
   logic        flush;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [4:0]  dec_warp_num;
   logic [2:0]  dec_split_table_num;
   logic [6:0]  dec_opcode;
   logic [4:0]  dec_rd;
   logic [2:0]  dec_funct3;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [6:0]  dec_funct7;
   logic [2:0]  dec_fmt;
   logic [31:0] dec_imm;
   logic        dec_illegal;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gelato_idecode dut (
      .clk                    (clk),
      .rst                    (rst),
      .ifetch_valid           (ifetch_valid),
      .ifetch_pc              (ifetch_pc),
      .ifetch_warp_num        (ifetch_warp_num),
      .ifetch_split_table_num (ifetch_split_table_num),
      .ifetch_inst            (ifetch_inst),
      .ifetch_consume         (ifetch_consume),
      .flush                  (flush),
      .dec_valid              (dec_valid),
      .dec_ready              (dec_ready),
      .dec_pc                 (dec_pc),
      .dec_warp_num           (dec_warp_num),
      .dec_split_table_num    (dec_split_table_num),
      .dec_opcode             (dec_opcode),
      .dec_rd                 (dec_rd),
      .dec_funct3             (dec_funct3),
      .dec_rs1                (dec_rs1),
      .dec_rs2                (dec_rs2),
      .dec_funct7             (dec_funct7),
      .dec_fmt                (dec_fmt),
      .dec_imm                (dec_imm),
      .dec_illegal            (dec_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
      ifetch_valid = 1'b1;
      ifetch_pc    = pc;
      ifetch_inst  = inst;
   endtask

   // One instruction through an empty FIFO: accept, inspect head, dequeue.
   task automatic run_vec(input string tag, input logic [31:0] inst,
                          input logic [2:0] fmt, input logic [31:0] imm,
                          input logic ill, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3);
      dec_ready = 1'b0;
      offer(32'h0000_1000, inst);
      #1 chk({tag, ".consume"}, 32'(ifetch_consume), 32'd1);
      step();
      ifetch_valid = 1'b0;
      #1;
      chk({tag, ".valid"}, 32'(dec_valid), 32'd1);
      chk({tag, ".fmt"},   32'(dec_fmt), 32'(fmt));
      chk({tag, ".imm"},   dec_imm, imm);
      chk({tag, ".ill"},   32'(dec_illegal), 32'(ill));
      chk({tag, ".rd"},    32'(dec_rd), 32'(rd));
      chk({tag, ".rs1"},   32'(dec_rs1), 32'(rs1));
      chk({tag, ".rs2"},   32'(dec_rs2), 32'(rs2));
      chk({tag, ".f3"},    32'(dec_funct3), 32'(f3));
      chk({tag, ".opc"},   32'(dec_opcode), 32'(inst[6:0]));
      dec_ready = 1'b1;
      step();
      #1 chk({tag, ".drained"}, 32'(dec_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      dec_ready = 1'b0;
      ifetch_warp_num = 5'd0;
      ifetch_split_table_num = 3'd0;
      offer(32'h0, 32'h0050_0093);

      // reset held with a pending instruction
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("rst.consume", 32'(ifetch_consume), 32'd0);
         chk("rst.valid",   32'(dec_valid), 32'd0);
      end

      // ADDI x1,x0,5
      rst = 1'b0;
      offer(32'h8000_0000, 32'h0050_0093);
      ifetch_warp_num = 5'd3;
      ifetch_split_table_num = 3'd6;
      dec_ready = 1'b1;
      #1 chk("addi.consume", 32'(ifetch_consume), 32'd1);
      chk("addi.valid_t", 32'(dec_valid), 32'd0);
      step();
      ifetch_valid = 1'b0;
      #1;
      chk("addi.valid", 32'(dec_valid), 32'd1);
      chk("addi.rd",    32'(dec_rd), 32'd1);
      chk("addi.rs1",   32'(dec_rs1), 32'd0);
      chk("addi.fmt",   32'(dec_fmt), 32'd1);
      chk("addi.imm",   dec_imm, 32'h0000_0005);
      chk("addi.pc",    dec_pc, 32'h8000_0000);
      chk("addi.warp",  32'(dec_warp_num), 32'd3);
      chk("addi.split", 32'(dec_split_table_num), 32'd6);
      step();
      #1 chk("addi.drained", 32'(dec_valid), 32'd0);

      // backpressure: three back-to-back offers, FIFO holds two
      dec_ready = 1'b0;
      ifetch_warp_num = 5'd1;
      offer(32'h0, 32'h0010_0093);
      #1 chk("bp.acc0", 32'(ifetch_consume), 32'd1);
      step();
      offer(32'h4, 32'h0020_0093);
      #1 chk("bp.acc1", 32'(ifetch_consume), 32'd1);
      step();
      offer(32'h8, 32'h0030_0093);
      #1 chk("bp.full", 32'(ifetch_consume), 32'd0);
      chk("bp.head0", dec_pc, 32'h0);
      step();
      dec_ready = 1'b1;
      #1 chk("bp.full_deq", 32'(ifetch_consume), 32'd0);
      chk("bp.head0b", dec_pc, 32'h0);
      step();
      #1 chk("bp.acc2", 32'(ifetch_consume), 32'd1);
      chk("bp.head1", dec_pc, 32'h4);
      chk("bp.imm1",  dec_imm, 32'h2);
      step();
      ifetch_valid = 1'b0;
      #1 chk("bp.head2", dec_pc, 32'h8);
      chk("bp.imm2", dec_imm, 32'h3);
      step();
      #1 chk("bp.drained", 32'(dec_valid), 32'd0);

      //      tag     inst          fmt   imm           ill  rd    rs1   rs2   f3
      run_vec("beq",  32'hFE20_8EE3, 3'd3, 32'hFFFF_FFFC, 1'b0, 5'd29, 5'd1, 5'd2, 3'd0);
      run_vec("jal",  32'h0080_006F, 3'd5, 32'h0000_0008, 1'b0, 5'd0,  5'd0, 5'd8, 3'd0);
      run_vec("ill",  32'h0000_0000, 3'd7, 32'h0000_0000, 1'b1, 5'd0,  5'd0, 5'd0, 3'd0);
      run_vec("sw",   32'h0020_A423, 3'd2, 32'h0000_0008, 1'b0, 5'd8,  5'd1, 5'd2, 3'd2);
      run_vec("lui",  32'h1234_5037, 3'd4, 32'h1234_5000, 1'b0, 5'd0,  5'd8, 5'd3, 3'd5);
      run_vec("addn", 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF, 1'b0, 5'd1,  5'd0, 5'd31, 3'd0);
      run_vec("add",  32'h0020_81B3, 3'd0, 32'h0000_0000, 1'b0, 5'd3,  5'd1, 5'd2, 3'd0);

      // flush with FIFO full, accept and dequeue both requested
      dec_ready = 1'b0;
      offer(32'h100, 32'h0010_0093);
      step();
      offer(32'h104, 32'h0010_0093);
      step();
      offer(32'h200, 32'h0070_0093);
      dec_ready = 1'b1;
      flush = 1'b1;
      #1 chk("fl.consume", 32'(ifetch_consume), 32'd0);
      chk("fl.valid_pre", 32'(dec_valid), 32'd1);
      step();
      flush = 1'b0;
      #1 chk("fl.valid", 32'(dec_valid), 32'd0);
      chk("fl.reaccept", 32'(ifetch_consume), 32'd1);
      step();
      ifetch_valid = 1'b0;
      #1 chk("fl.new_valid", 32'(dec_valid), 32'd1);
      chk("fl.new_pc",  dec_pc, 32'h200);
      chk("fl.new_imm", dec_imm, 32'h7);
      step();

      // asynchronous reset mid-operation discards buffered entries
      dec_ready = 1'b0;
      offer(32'h300, 32'h0010_0093);
      step();
      offer(32'h304, 32'h0010_0093);
      #1 chk("ar.valid_pre", 32'(dec_valid), 32'd1);
      #1 rst = 1'b1;
      #1 chk("ar.valid", 32'(dec_valid), 32'd0);
      chk("ar.consume", 32'(ifetch_consume), 32'd0);
      step();
      rst = 1'b0;
      #1 chk("ar.consume_after", 32'(ifetch_consume), 32'd1);
      step();
      ifetch_valid = 1'b0;
      #1 chk("ar.pc_after", dec_pc, 32'h304);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
